// File: rtl/adder_pkg.sv
// Shared constants and helpers for the sliced-adder sequencer.
package adder_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned SLICE_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement overflow: like-signed operands with a differently signed result.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder slice.
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle 32-bit adder: walks one narrow slice LSB-first, carry held in a register.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SLICES - 1);

  if ((DATA_W % SLICE_W) != 0) begin : g_bad_slice
    $error("DATA_W must be a multiple of SLICE_W");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, part_q, part_d, sum_d;
  logic               carry_q, carry_d, cout_d, ovf_d, out_valid_d, in_ready_d;
  logic [31:0]        base;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;

  assign base = 32'(cnt_q) * SLICE_W;

  // Single shared slice; operand bits are steered in by the slice counter.
  adder_slice #(.W(SLICE_W)) u_slice (
    .a    (a_q[base +: SLICE_W]),
    .b    (b_q[base +: SLICE_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      part_q    <= part_d;
      carry_q   <= carry_d;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

  // Partial sums accumulate in part_q; visible outputs load only on the last slice.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    part_d      = part_q;
    carry_d     = carry_q;
    sum_d       = sum;
    cout_d      = cout;
    ovf_d       = ovf;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;
    case (state_q)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        part_d[base +: SLICE_W] = slice_s;
        carry_d = slice_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          sum_d       = part_d;
          cout_d      = slice_c;
          ovf_d       = ovf_detect(a_q[DATA_W-1], b_q[DATA_W-1], part_d[DATA_W-1]);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed plus random operand pairs checked against a plain 33-bit arithmetic model.
module tb_adder_seq_ctrl;

  localparam int NUM_SLICES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [31:0] held_sum = '0;

  adder_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input int stall, input bit pulse);
    logic [32:0] full;
    logic        e_ovf;
    int          k;
    full  = {1'b0, ta} + {1'b0, tb} + 33'(tc);
    e_ovf = (ta[31] == tb[31]) && (full[31] != ta[31]);
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      check("no_partial_sum", sum, held_sum);
      step();
      k++;
    end
    check("latency", 32'(k), 32'(NUM_SLICES));
    check("sum", sum, full[31:0]);
    check("cout", 32'(cout), 32'(full[32]));
    check("ovf", 32'(ovf), 32'(e_ovf));
    held_sum = full[31:0];
    for (int s = 0; s < stall; s++) begin
      if (pulse && s == 3) begin
        a = '0; b = '0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", sum, full[31:0]);
      check("stall_cout_ovf", {30'd0, cout, ovf}, {30'd0, full[32], e_ovf});
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_sum_held", sum, full[31:0]);
  endtask

  initial begin
    int   k;
    logic seen;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);
    do_op(-32'sd50, -32'sd100, 1'b1, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 1'b0);
    do_op(32'd1234, -32'sd5678, 1'b1, 10, 1'b1);

    // Reset in the second RUN cycle drops the op.
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    a = -32'sd9876; b = 32'd5432; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_sum", sum, 32'd0);
    check("midrun_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    held_sum = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("no_result_after_rst", 32'(seen), 32'd0);
    do_op(32'd0, 32'd0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++)
      do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
